// File: rtl/niosii_pio_edge_port.sv
// niosii_pio_edge_port
//   Avalon-MM general-purpose I/O port for the NIOS II data master.
//   It provides DATA_W registered outputs with atomic bit set and clear.
//   It has DATA_W synchronised inputs, each with a sticky edge-capture bit.
//   It drives a maskable level interrupt built from the captured edges.
//
// Optional feature macro: PIO_PULSE_EN
//   When defined, address 6 becomes a one-shot pulse generator.
//   Each bit written there goes high on out_port for PULSE_LEN cycles.
//   When undefined, there is no pulse logic, and address 6 reads 0 and ignores writes.
//
// Ports
//   clk        in   1       system clock
//   reset      in   1       asynchronous, active-high reset
//   address    in   3       word address (0 OUT, 1 IN, 2 MASK, 3 EDGE, 4 SET, 5 CLR, 6 PULSE)
//   chipselect in   1       slave select
//   write_n    in   1       active-low write strobe
//   writedata  in   32      write data; bits above DATA_W are ignored
//   readdata   out  32      read data, zero-extended above DATA_W, combinational from address
//   in_port    in   DATA_W  asynchronous external inputs
//   out_port   out  DATA_W  external outputs (OR of register state only)
//   irq        out  1       level interrupt: |(edge_cap & irq_mask)
//
// Bus handshake: this slave never stalls. A write is accepted in every cycle
// in which chipselect=1 and write_n=0. It commits at the clock edge that ends
// that cycle. A read has zero latency: readdata follows address combinationally
// and does not depend on chipselect.
module niosii_pio_edge_port #(
  parameter int unsigned       DATA_W      = 8,
  parameter logic [DATA_W-1:0] OUT_RESET   = '0,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter int unsigned       EDGE_TYPE   = 0,
  parameter int unsigned       PULSE_LEN   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic              irq
);

  localparam logic [2:0] ADDR_OUT   = 3'd0;
  localparam logic [2:0] ADDR_IN    = 3'd1;
  localparam logic [2:0] ADDR_MASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGE  = 3'd3;
  localparam logic [2:0] ADDR_SET   = 3'd4;
  localparam logic [2:0] ADDR_CLR   = 3'd5;
  localparam logic [2:0] ADDR_PULSE = 3'd6;

  localparam int unsigned SYNC_W = SYNC_STAGES * DATA_W;

  logic              wr_en;
  logic [DATA_W-1:0] wd;
  logic              unused_wd;

  assign wr_en = chipselect & ~write_n;
  assign wd    = writedata[DATA_W-1:0];
  // The upper writedata bits are deliberately ignored.
  assign unused_wd = ^writedata;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] out_reg_q,  out_reg_d;
  logic [DATA_W-1:0] irq_mask_q, irq_mask_d;
  logic [DATA_W-1:0] edge_cap_q, edge_cap_d;
  logic [DATA_W-1:0] prev_q,     prev_d;
  // The synchroniser chain is packed. Stage 0 is the low slice, and the
  // last stage is the high slice.
  logic [SYNC_W-1:0] sync_q,     sync_d;

  logic [DATA_W-1:0] sync_out;
  logic [DATA_W-1:0] edge_det;

  assign sync_out = sync_q[SYNC_W-1 -: DATA_W];

  // Edge detection compares the last synchroniser stage with the value it
  // held one cycle earlier.
  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det =  sync_out & ~prev_q;
      1:       edge_det = ~sync_out &  prev_q;
      default: edge_det =  sync_out ^  prev_q;
    endcase
  end

  always_comb begin
    out_reg_d  = out_reg_q;
    irq_mask_d = irq_mask_q;
    edge_cap_d = edge_cap_q;
    sync_d     = {sync_q[SYNC_W-DATA_W-1:0], in_port};
    prev_d     = sync_out;

    if (wr_en) begin
      case (address)
        ADDR_OUT:  out_reg_d  = wd;
        ADDR_MASK: irq_mask_d = wd;
        ADDR_EDGE: edge_cap_d = edge_cap_q & ~wd;
        ADDR_SET:  out_reg_d  = out_reg_q | wd;
        ADDR_CLR:  out_reg_d  = out_reg_q & ~wd;
        default:   ;
      endcase
    end

    // The set is applied after the W1C clear. A new edge is therefore never
    // lost to a clear in the same cycle.
    edge_cap_d = edge_cap_d | edge_det;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_reg_q  <= OUT_RESET;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      prev_q     <= '0;
      sync_q     <= '0;
    end else begin
      out_reg_q  <= out_reg_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      prev_q     <= prev_d;
      sync_q     <= sync_d;
    end
  end

  assign irq = |(edge_cap_q & irq_mask_q);

  // ---------------------------------------------------------------------------
  // One-shot pulse generator
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] pulse_rd;

`ifdef PIO_PULSE_EN
  localparam logic [15:0] PULSE_RELOAD = 16'(PULSE_LEN - 1);

  logic [DATA_W-1:0] pulse_mask_q, pulse_mask_d;
  logic [15:0]       pulse_cnt_q,  pulse_cnt_d;

  // The counter is reloaded on every write. A rewrite therefore restarts the
  // timing for all pending bits. The mask drops on the edge after the count
  // reaches 0, which gives exactly PULSE_LEN high cycles.
  always_comb begin
    pulse_mask_d = pulse_mask_q;
    pulse_cnt_d  = pulse_cnt_q;
    if (wr_en && (address == ADDR_PULSE)) begin
      pulse_mask_d = pulse_mask_q | wd;
      pulse_cnt_d  = PULSE_RELOAD;
    end else if (pulse_mask_q != '0) begin
      if (pulse_cnt_q == 16'd0) begin
        pulse_mask_d = '0;
      end else begin
        pulse_cnt_d = pulse_cnt_q - 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_mask_q <= '0;
      pulse_cnt_q  <= '0;
    end else begin
      pulse_mask_q <= pulse_mask_d;
      pulse_cnt_q  <= pulse_cnt_d;
    end
  end

  assign pulse_rd = pulse_mask_q;
  assign out_port = out_reg_q | pulse_mask_q;
`else
  assign pulse_rd = '0;
  assign out_port = out_reg_q;
`endif

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rd_val;

  always_comb begin
    rd_val = '0;
    case (address)
      ADDR_OUT:   rd_val = out_reg_q;
      ADDR_IN:    rd_val = sync_out;
      ADDR_MASK:  rd_val = irq_mask_q;
      ADDR_EDGE:  rd_val = edge_cap_q;
      ADDR_PULSE: rd_val = pulse_rd;
      default:    rd_val = '0;
    endcase
  end

  assign readdata = 32'(rd_val);

endmodule
